// File: rtl/pipe_stage1.sv
// pipe_stage1: JAM-1 stage 1, assembles opcode+operand bytes and issues them registered.
// Define PIPE1_INSTR_COUNT_EN to add the 16-bit InstrCount issue counter.
module pipe_stage1 #(
    parameter logic [7:0] NOP_OPCODE = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  Pipe0Out,
    input  logic        BusRequest,
    input  logic        Stall,
    input  logic        Flush,
    output logic [7:0]  Pipe1Out,
    output logic [15:0] Pipe1Imm,
    output logic        Pipe1Valid,
    output logic        OperandPending
`ifdef PIPE1_INSTR_COUNT_EN
    ,
    output logic [15:0] InstrCount
`endif
);
    typedef enum logic [1:0] {S_OPCODE, S_IMM_LO, S_IMM_HI} state_t;
    state_t state, state_n;
    logic [7:0] opc, opc_n, lo, lo_n, iss_op, out_n;
    logic [15:0] iss_imm, imm_n;
    logic issue, accept, valid_n;
    assign OperandPending = state != S_OPCODE;
    always_comb begin
        accept = !Flush && !Stall && !BusRequest;
        state_n = state;
        opc_n = opc;
        lo_n = lo;
        issue = 1'b0;
        iss_op = opc;
        iss_imm = '0;
        if (Flush)
            state_n = S_OPCODE;
        else if (accept)
            case (state)
                S_OPCODE: begin
                    opc_n = Pipe0Out;
                    iss_op = Pipe0Out;
                    issue = !Pipe0Out[7];
                    state_n = Pipe0Out[7] ? S_IMM_LO : S_OPCODE;
                end
                S_IMM_LO: begin
                    // opc[7] is known set here, so opc[6] selects 1 vs 2 operands
                    lo_n = Pipe0Out;
                    issue = !opc[6];
                    iss_imm = {8'h00, Pipe0Out};
                    state_n = opc[6] ? S_IMM_HI : S_OPCODE;
                end
                S_IMM_HI: begin
                    issue = 1'b1;
                    iss_imm = {Pipe0Out, lo};
                    state_n = S_OPCODE;
                end
                default: state_n = S_OPCODE;
            endcase
        out_n = Flush ? NOP_OPCODE : Stall ? Pipe1Out : issue ? iss_op : NOP_OPCODE;
        imm_n = Flush ? 16'h0 : Stall ? Pipe1Imm : issue ? iss_imm : 16'h0;
        valid_n = Flush ? 1'b0 : Stall ? Pipe1Valid : issue;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_OPCODE;
            opc <= '0;
            lo <= '0;
            Pipe1Out <= NOP_OPCODE;
            Pipe1Imm <= '0;
            Pipe1Valid <= 1'b0;
        end else begin
            state <= state_n;
            opc <= opc_n;
            lo <= lo_n;
            Pipe1Out <= out_n;
            Pipe1Imm <= imm_n;
            Pipe1Valid <= valid_n;
        end
    end
`ifdef PIPE1_INSTR_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            InstrCount <= '0;
        else if (issue)
            InstrCount <= InstrCount + 16'd1;
    end
`endif
endmodule

// File: tb/tb_pipe_stage1.sv
// tb_pipe_stage1: scoreboard bench for pipe_stage1 with a byte-list reference model.
module tb_pipe_stage1;
    localparam logic [7:0] NOP = 8'h00;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [7:0] Pipe0Out = 8'h00;
    logic BusRequest = 1'b0;
    logic Stall = 1'b0;
    logic Flush = 1'b0;
    logic [7:0] Pipe1Out;
    logic [15:0] Pipe1Imm;
    logic Pipe1Valid;
    logic OperandPending;
`ifdef PIPE1_INSTR_COUNT_EN
    logic [15:0] InstrCount;
`endif
    pipe_stage1 #(.NOP_OPCODE(NOP)) dut (
        .clk(clk),
        .reset(reset),
        .Pipe0Out(Pipe0Out),
        .BusRequest(BusRequest),
        .Stall(Stall),
        .Flush(Flush),
        .Pipe1Out(Pipe1Out),
        .Pipe1Imm(Pipe1Imm),
        .Pipe1Valid(Pipe1Valid),
        .OperandPending(OperandPending)
`ifdef PIPE1_INSTR_COUNT_EN
        ,
        .InstrCount(InstrCount)
`endif
    );
    always #5 clk = ~clk;

    logic [23:0] expq[$];
    logic [7:0] part[$];
    logic exp_pend = 1'b0;
    logic [15:0] exp_cnt = 16'h0;
    logic done = 1'b0;
    int checks = 0;
    int errors = 0;

    // Drive one cycle of inputs and apply its effect to the reference model.
    task automatic step(input logic [7:0] b, input logic br, input logic st, input logic fl, input logic rs);
        int n;
        @(negedge clk);
        Pipe0Out = b;
        BusRequest = br;
        Stall = st;
        Flush = fl;
        reset = rs;
        if (rs) begin
            part.delete();
            exp_cnt = 16'h0;
        end else if (fl) begin
            part.delete();
        end else if (!st && !br) begin
            part.push_back(b);
            n = part[0][7:6] == 2'b11 ? 2 : part[0][7:6] == 2'b10 ? 1 : 0;
            if (part.size() == n + 1) begin
                expq.push_back({part[0], n == 2 ? {part[2], part[1]} : n == 1 ? {8'h00, part[1]} : 16'h0000});
                exp_cnt = exp_cnt + 16'd1;
                part.delete();
            end
        end
        exp_pend = part.size() != 0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
        end
    endtask

    initial begin
        step(8'h00, 0, 0, 0, 1);
        step(8'h00, 0, 0, 0, 1);
        step(8'h12, 0, 0, 0, 0);
        step(8'h34, 0, 0, 0, 0);
        step(8'hC5, 0, 0, 0, 0);
        step(8'hAA, 0, 0, 0, 0);
        step(8'hBB, 0, 0, 0, 0);
        step(8'h85, 0, 0, 0, 0);
        step(8'h99, 1, 0, 0, 0);
        step(8'h98, 1, 0, 0, 0);
        step(8'h7E, 0, 0, 0, 0);
        step(8'hC0, 0, 0, 0, 0);
        step(8'h11, 0, 0, 0, 0);
        step(8'h55, 0, 0, 1, 0);
        step(8'h01, 0, 0, 0, 0);
        step(8'hC0, 0, 0, 0, 0);
        step(8'h11, 0, 0, 0, 0);
        step(8'h55, 0, 0, 0, 1);
        step(8'h01, 0, 0, 0, 0);
        step(8'h20, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(8'h21, 0, 1, 0, 0);
        step(8'h85, 0, 0, 0, 0);
        step(8'h44, 0, 1, 1, 0);
        step(8'h02, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++)
            step(8'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
`ifdef PIPE1_INSTR_COUNT_EN
        step(8'h00, 0, 0, 0, 1);
        for (int i = 0; i < 65537; i++) step(8'h01, 0, 0, 0, 0);
`endif
        for (int i = 0; i < 4; i++) step(8'h00, 1, 0, 0, 0);
        done = 1'b1;
    end

    initial begin
        logic held;
        logic [7:0] p_out;
        logic [15:0] p_imm;
        logic p_val;
        logic [23:0] e;
        p_out = NOP;
        p_imm = 16'h0;
        p_val = 1'b0;
        while (!done) begin
            @(posedge clk);
            held = Stall && !Flush && !reset;
            #1;
            if (held) begin
                check("hold_out", 32'(Pipe1Out), 32'(p_out));
                check("hold_imm", 32'(Pipe1Imm), 32'(p_imm));
                check("hold_valid", 32'(Pipe1Valid), 32'(p_val));
            end else if (Pipe1Valid) begin
                if (expq.size() == 0) begin
                    check("spurious_issue", 32'(Pipe1Out), 32'hFFFF_FFFF);
                end else begin
                    e = expq.pop_front();
                    check("issue_out", 32'(Pipe1Out), 32'(e[23:16]));
                    check("issue_imm", 32'(Pipe1Imm), 32'(e[15:0]));
                end
            end else begin
                check("nop_out", 32'(Pipe1Out), 32'(NOP));
                check("nop_imm", 32'(Pipe1Imm), 32'h0);
            end
            check("pending", 32'(OperandPending), 32'(exp_pend));
`ifdef PIPE1_INSTR_COUNT_EN
            check("count", 32'(InstrCount), 32'(exp_cnt));
`endif
            p_out = Pipe1Out;
            p_imm = Pipe1Imm;
            p_val = Pipe1Valid;
        end
        check("leftover_expected", 32'(expq.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
